// File: rtl/sram_data_controller_pkg.sv
// Shared definitions for the SRAM data controller:
// FSM encoding, default base address, SRAM data width.
package sram_data_controller_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned BASE_ADDR_DEF = 1024;
   localparam int          DATA_W        = 16;
   localparam int          CNT_W         = 4;

endpackage

// File: rtl/sram_data_controller_if.sv
// MEM-stage request/response bundle plus the SRAM pad signals.
// master = pipeline/pad side, slave = controller.
interface sram_data_controller_if #(
   parameter int SRAM_ADDR_W = 18
);
   import sram_data_controller_pkg::*;

   logic                   rd_en;
   logic                   wr_en;
   logic [31:0]            address;
   logic [31:0]            write_data;
   logic [31:0]            read_data;
   logic                   ready;
   logic [SRAM_ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0]      sram_dq_out;
   logic [DATA_W-1:0]      sram_dq_in;
   logic                   sram_dq_oe;
   logic                   sram_we_n;

   modport master (
      output rd_en, wr_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out,
      input  sram_dq_oe, sram_we_n
   );

   modport slave (
      input  rd_en, wr_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out,
      output sram_dq_oe, sram_we_n
   );

endinterface

// File: rtl/sram_data_controller_wait_counter.sv
// Per-half wait counter; wraps to 0 after its last cycle
// so the same counter times both the LO and HI halves.
module sram_wait_counter
   import sram_data_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   output logic [CNT_W-1:0] wait_cnt,
   output logic             last
);

   assign last = (wait_cnt == CNT_W'(WAIT_CYCLES - 1));

   // count 0..WAIT_CYCLES-1 while enabled, held at 0 when cleared
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wait_cnt <= '0;
      end else if (en) begin
         if (last)
            wait_cnt <= '0;
         else
            wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/sram_data_controller.sv
// Splits each 32-bit MEM access into two timed 16-bit SRAM accesses.
// Optional write posting: define SRAM_WRITE_BUFFER_EN.
module sram_data_controller
   import sram_data_controller_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 5,
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
   parameter int          SRAM_ADDR_W = 18
) (
   input logic                  clk,
   input logic                  rst,
   sram_data_controller_if.slave bus
);

   state_t                 state;
   state_t                 state_nx;
   logic                   req;
   logic                   start;
   logic                   active;
   logic                   half;
   logic                   post_now;
   logic                   wr_q;
   logic                   post_q;
   logic [SRAM_ADDR_W-2:0] idx_q;
   logic [31:0]            data_q;
   logic [31:0]            offset;
   logic [31:0]            read_data;
   logic [CNT_W-1:0]       wait_cnt;
   logic                   last;
   logic                   unused_bits;

   assign req    = bus.rd_en | bus.wr_en;
   assign offset = bus.address - 32'(BASE_ADDR);
   assign active = (state == LO) | (state == HI);
   assign half   = (state == HI);

   assign unused_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0], wait_cnt};

`ifdef SRAM_WRITE_BUFFER_EN
   assign post_now  = bus.wr_en;
   assign bus.ready = ~req | (state == DONE) | ((state == IDLE) & bus.wr_en);
`else
   assign post_now  = 1'b0;
   assign bus.ready = ~req | (state == DONE);
`endif

   sram_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_wait (
      .clk      (clk),
      .rst      (rst),
      .clear    (~active),
      .en       (active),
      .wait_cnt (wait_cnt),
      .last     (last)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // next state; posted writes return straight to IDLE
   always_comb begin
      state_nx = state;
      start    = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) begin
               state_nx = LO;
               start    = 1'b1;
            end
         end
         LO:   if (last) state_nx = HI;
         HI:   if (last) state_nx = post_q ? IDLE : DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // capture op, word index and store data when an access starts
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= 1'b0;
         post_q <= 1'b0;
         idx_q  <= '0;
         data_q <= '0;
      end else if (start) begin
         wr_q   <= bus.wr_en;
         post_q <= post_now;
         idx_q  <= offset[SRAM_ADDR_W:2];
         data_q <= bus.write_data;
      end
   end

   // load each read half on the last cycle of its window
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else if (active && !wr_q && last) begin
         if (half)
            read_data[31:16] <= bus.sram_dq_in;
         else
            read_data[15:0]  <= bus.sram_dq_in;
      end
   end

   assign bus.read_data   = read_data;
   assign bus.sram_addr   = {idx_q, half};
   assign bus.sram_dq_out = half ? data_q[31:16] : data_q[15:0];
   assign bus.sram_dq_oe  = active & wr_q;
   assign bus.sram_we_n   = ~(active & wr_q & ~last);

endmodule

// File: tb/tb_sram_data_controller.sv
// Directed bench for sram_data_controller with a timeline model
// of each access and a behavioural async SRAM on the pads.
module tb_sram_data_controller;

   localparam int          W    = 5;
   localparam int unsigned BASE = 1024;
`ifdef SRAM_WRITE_BUFFER_EN
   localparam bit BUF    = 1'b1;
   localparam int WR_LAT = 0;
   localparam int RD_AFTER_WR = 21;
`else
   localparam bit BUF    = 1'b0;
   localparam int WR_LAT = 11;
   localparam int RD_AFTER_WR = 11;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sram_data_controller_if #(.SRAM_ADDR_W(18)) bus ();

   sram_data_controller #(
      .WAIT_CYCLES (W),
      .BASE_ADDR   (BASE),
      .SRAM_ADDR_W (18)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] sram_mem [0:1023];
   logic [31:0] ref_mem  [0:511];
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   assign bus.sram_dq_in = sram_mem[bus.sram_addr[9:0]];

   // async SRAM: a location takes the pad value while WE is low
   always @(posedge clk)
      if (bus.sram_dq_oe && !bus.sram_we_n)
         sram_mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;

   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endtask

   // model: ph = cycles since the access started (0 = idle)
   int          ph = 0;
   bit          model_ok = 1'b0;
   bit          m_wr;
   bit          m_post;
   int          m_idx;
   logic [31:0] m_data;
   logic [31:0] m_rd = '0;

   // advance the access timeline on each clock edge
   always @(posedge clk) begin
      if (rst) begin
         ph = 0;
         m_rd = '0;
         model_ok = 1'b1;
      end else if (ph == 0) begin
         if (bus.rd_en || bus.wr_en) begin
            ph     = 1;
            m_wr   = bus.wr_en;
            m_post = BUF && bus.wr_en;
            m_idx  = int'((bus.address - BASE) >> 2);
            m_data = bus.write_data;
         end
      end else begin
         if (ph == W && !m_wr)
            m_rd[15:0] = ref_mem[m_idx][15:0];
         if (ph == 2*W) begin
            if (m_wr) ref_mem[m_idx] = m_data;
            else      m_rd[31:16] = ref_mem[m_idx][31:16];
         end
         if ((ph == 2*W && m_post) || ph == 2*W + 1) ph = 0;
         else ph++;
      end
   end

   bit act_m;
   bit half_m;
   bit req_m;
   bit rdy_m;
   int pos_m;

   // compare every output against the model mid-cycle
   always @(negedge clk) begin
      if (model_ok) begin
         req_m  = bus.rd_en || bus.wr_en;
         act_m  = (ph >= 1) && (ph <= 2*W);
         half_m = ph > W;
         pos_m  = (ph - 1) % W;
         rdy_m  = !req_m || ph == 2*W + 1 || (BUF && ph == 0 && bus.wr_en);
         chk("ready", 32'(bus.ready), 32'(rdy_m));
         chk("dq_oe", 32'(bus.sram_dq_oe), 32'(act_m && m_wr));
         chk("we_n", 32'(bus.sram_we_n),
             32'(!(act_m && m_wr && pos_m != W - 1)));
         chk("read_data", bus.read_data, m_rd);
         if (act_m)
            chk("sram_addr", 32'(bus.sram_addr), 32'(2*m_idx + int'(half_m)));
         if (act_m && m_wr)
            chk("dq_out", 32'(bus.sram_dq_out),
                32'(half_m ? m_data[31:16] : m_data[15:0]));
      end
   end

   logic [15:0] pr_addr [0:63];
   logic [15:0] pr_dq   [0:63];
   int lo_low;
   int hi_low;

   task automatic access(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d, output int lat,
                         output int rdy_cyc);
      int start;
      bit got;
      got = 1'b0;
      lat = -1;
      rdy_cyc = -1;
      bus.rd_en = r;
      bus.wr_en = w;
      bus.address = a;
      bus.write_data = d;
      start = cyc;
      lo_low = 0;
      hi_low = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.sram_dq_oe && !bus.sram_we_n) begin
            if (bus.sram_addr[0]) hi_low++;
            else lo_low++;
         end
         if (k < 64) begin
            pr_addr[k] = bus.sram_addr[15:0];
            pr_dq[k]   = bus.sram_dq_out;
         end
         if (bus.ready) begin
            lat = cyc - start;
            rdy_cyc = cyc;
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: ready never rose for addr %h", a);
      end
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
   endtask

   int lat;
   int rc;
   int rc2;
   int t0;
   int oe_cnt;

   initial begin
      for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
      for (int i = 0; i < 512; i++) ref_mem[i] = '0;
      sram_mem[0] = 16'h1111;
      sram_mem[1] = 16'h2222;
      sram_mem[2] = 16'h3333;
      sram_mem[3] = 16'h4444;
      ref_mem[0]  = 32'h2222_1111;
      ref_mem[1]  = 32'h4444_3333;
      rst = 1'b1;
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      bus.address = '0;
      bus.write_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_read_data", bus.read_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      access(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, lat, rc);
      chk("wr_latency", 32'(lat), 32'(WR_LAT));
`ifndef SRAM_WRITE_BUFFER_EN
      chk("wr_lo_addr", 32'(pr_addr[1]), 32'd4);
      chk("wr_lo_dq", 32'(pr_dq[1]), 32'h0000_BEEF);
      chk("wr_hi_addr", 32'(pr_addr[6]), 32'd5);
      chk("wr_hi_dq", 32'(pr_dq[6]), 32'h0000_DEAD);
      chk("wr_lo_we_cnt", 32'(lo_low), 32'd4);
      chk("wr_hi_we_cnt", 32'(hi_low), 32'd4);
`endif
      access(1'b1, 1'b0, 32'd1032, 32'h0, lat, rc);
      chk("rd_latency", 32'(lat), 32'(RD_AFTER_WR));
      chk("rd_data", bus.read_data, 32'hDEAD_BEEF);

      @(posedge clk);
      #1;
      t0 = cyc;
      access(1'b1, 1'b0, 32'd1024, 32'h0, lat, rc);
      chk("b2b_first_data", bus.read_data, 32'h2222_1111);
      access(1'b1, 1'b0, 32'd1028, 32'h0, lat, rc2);
      chk("b2b_second_ready", 32'(rc2 - t0), 32'd23);
      chk("b2b_second_data", bus.read_data, 32'h4444_3333);

      access(1'b1, 1'b1, 32'd1040, 32'h1234_5678, lat, rc);
      chk("both_high_latency", 32'(lat), 32'(WR_LAT));
      access(1'b1, 1'b0, 32'd1040, 32'h0, lat, rc);
      chk("both_high_readback", bus.read_data, 32'h1234_5678);

      bus.rd_en = 1'b1;
      bus.address = 32'd1024;
      repeat (3) @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("flush_data", bus.read_data, 32'h2222_1111);

      bus.wr_en = 1'b1;
      bus.address = 32'd1100;
      bus.write_data = 32'hCAFE_F00D;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      oe_cnt = 0;
      @(negedge clk);
      chk("rst_mid_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_mid_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_mid_read_data", bus.read_data, 32'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.sram_dq_oe || !bus.sram_we_n) oe_cnt++;
      end
      chk("rst_mid_activity", 32'(oe_cnt), 32'd0);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
